uart_cmd_rx: RTL and testbench

Serial command receiver sitting directly upstream of the `main` block's `RX` input path: it deserializes 8N1 UART frames from the host at `BAUD_RATE`, validates framing, splits each byte into a 4-bit command and 4-bit argument, and buffers them in a 4-entry FIFO. Decoded commands reach the correlator control logic through a valid/ready handshake. It runs entirely in the `sysclk` domain.

---
 rtl/xc_uart_pkg.sv | 30 +++
 rtl/uart_cmd_rx_if.sv | 24 ++
 rtl/uart_rx_byte.sv | 169 ++++++++++++++++
 rtl/uart_cmd_rx.sv | 92 +++++++++
 tb/tb_uart_cmd_rx.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xc_uart_pkg.sv
// Shared types and constants for the UART command receiver.
// UART_CMD_PARITY_EN selects 8E1 framing; default is 8N1.
package xc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    typedef struct packed {
        logic [3:0] arg;
        logic [3:0] cmd;
    } cmd_t;

    localparam logic [3:0] CMD_NOP   = 4'h0;
    localparam logic [3:0] CMD_START = 4'h1;
    localparam logic [3:0] CMD_STOP  = 4'h2;
    localparam logic [3:0] CMD_CLEAR = 4'h3;
    localparam logic [3:0] CMD_READ  = 4'h4;
    localparam logic [3:0] CMD_SETUP = 4'h5;

    function automatic int bit_clks(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Command handshake bundle between the UART receiver and its consumer.
// Master drives the head entry, slave answers with ready.
interface uart_cmd_rx_if;

    logic [3:0] cmd;
    logic [3:0] arg;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (
        output cmd,
        output arg,
        output cmd_valid,
        input  cmd_ready
    );

    modport slave (
        input  cmd,
        input  arg,
        input  cmd_valid,
        output cmd_ready
    );

endinterface

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: line synchronizer, framing FSM, byte strobe.
// UART_CMD_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_byte
    import xc_uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 10000000,
    parameter int BAUD_RATE     = 57600
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       rx,
    output logic       byte_stb,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT_CLKS = bit_clks(CLK_FREQUENCY, BAUD_RATE);
    localparam int CW       = $clog2(BIT_CLKS);

    localparam logic [CW-1:0] HALF_CNT = CW'(BIT_CLKS / 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(BIT_CLKS - 1);

    logic          rx_m;
    logic          rx_s;
    logic          rx_q;
    logic [1:0]    fill;
    logic          fall;
    logic          expire;
    logic          par_ok;
    logic          err_n;

    rx_state_e     state;
    rx_state_e     state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;

`ifdef UART_CMD_PARITY_EN
    logic          par_q;
    logic          par_n;

    assign par_ok = ~^{shreg, par_q};
`else
    assign par_ok = 1'b1;
`endif

    assign fall      = rx_q & ~rx_s;
    assign expire    = (cnt == '0);
    assign busy      = (state != IDLE);
    assign byte_data = shreg;

    // Two-flop synchronizer; edge history only trusted once the pipe holds real samples
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b0;
            fill <= 2'b00;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s & fill[1];
            fill <= {fill[0], 1'b1};
        end
    end

    // Framing state, baud counter, shift register and error pulse
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef UART_CMD_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            frame_err <= err_n;
`ifdef UART_CMD_PARITY_EN
            par_q     <= par_n;
`endif
        end
    end

    // Next-state logic: sample mid-bit on each counter expiry
    always_comb begin
        state_n   = state;
        cnt_n     = expire ? '0 : cnt - 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        byte_stb  = 1'b0;
        err_n     = 1'b0;
`ifdef UART_CMD_PARITY_EN
        par_n     = par_q;
`endif
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    cnt_n   = HALF_CNT;
                end
            end
            START: begin
                if (expire) begin
                    if (!rx_s) begin
                        state_n   = DATA;
                        cnt_n     = FULL_CNT;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_n   = {rx_s, shreg[7:1]};
                    cnt_n     = FULL_CNT;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_CMD_PARITY_EN
            PARITY: begin
                if (expire) begin
                    par_n   = rx_s;
                    cnt_n   = FULL_CNT;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (expire) begin
                    if (rx_s) begin
                        state_n  = IDLE;
                        byte_stb = par_ok;
                        err_n    = ~par_ok;
                    end else begin
                        state_n = BREAK;
                        err_n   = 1'b1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: byte framing plus a small command FIFO.
// UART_CMD_PARITY_EN switches the serial format to 8E1.
module uart_cmd_rx
    import xc_uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 10000000,
    parameter int BAUD_RATE     = 57600,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic          sysclk,
    input  logic          reset_n,
    input  logic          rx,
    uart_cmd_rx_if.master cmd_if,
    output logic          frame_err,
    output logic          overflow,
    output logic          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic          byte_stb;
    logic [7:0]    byte_data;

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    cmd_t          last_q;
    cmd_t          head;
    logic          valid;
    logic          full;
    logic          pop;
    logic          push;

    uart_rx_byte #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .BAUD_RATE     (BAUD_RATE)
    ) u_rx (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .rx        (rx),
        .byte_stb  (byte_stb),
        .byte_data (byte_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = valid & cmd_if.cmd_ready;
    assign push  = byte_stb & (~full | pop);
    assign head  = valid ? mem[rd_ptr] : last_q;

    assign cmd_if.cmd       = head.cmd;
    assign cmd_if.arg       = head.arg;
    assign cmd_if.cmd_valid = valid;

    // FIFO storage; contents are only visible while valid
    always_ff @(posedge sysclk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= cmd_t'(byte_data);
        end
    end

    // Pointers, occupancy, held output and sticky overflow
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_q   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (byte_stb && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed frames plus random traffic.
// Build with UART_CMD_PARITY_EN to exercise the 8E1 variant.
module tb_uart_cmd_rx;

    localparam int CLK_FREQUENCY = 10000000;
    localparam int BAUD_RATE     = 57600;
    localparam int FIFO_DEPTH    = 4;
    localparam int BIT           = CLK_FREQUENCY / BAUD_RATE;
`ifdef UART_CMD_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // pin edge -> sync (2) -> edge detect (1) -> half bit -> remaining bits -> valid (1)
    localparam int LAT = 3 + BIT / 2 + (NBITS - 1) * BIT + 1;

    logic sysclk = 1'b0;
    logic reset_n;
    logic rx;
    logic frame_err;
    logic overflow;
    logic busy;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .CLK_FREQUENCY (CLK_FREQUENCY),
        .BAUD_RATE     (BAUD_RATE),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .rx        (rx),
        .cmd_if    (bus),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         t0;
    int         e0;
    int         valid_cycles = 0;
    int         err_pulses = 0;
    int         valid_rise[$];
    int         err_rise[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic       pv = 1'b0;
    logic       pe = 1'b0;

    logic [7:0] d;
    bit         s_ok;
    bit         p_ok;
    bit         rdy;
    bit         ovf_exp;
    int         occ;
    int         n_err_exp;
    int         diff;

    // cycle counter for latency measurements
    always @(posedge sysclk) cyc = cyc + 1;

    // passive monitor: pops, valid/error activity and their rising edges
    always @(negedge sysclk) begin
        if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1)
            got.push_back({bus.arg, bus.cmd});
        if (bus.cmd_valid === 1'b1) valid_cycles++;
        if (bus.cmd_valid === 1'b1 && !pv) valid_rise.push_back(cyc);
        if (frame_err === 1'b1) err_pulses++;
        if (frame_err === 1'b1 && !pe) err_rise.push_back(cyc);
        pv = (bus.cmd_valid === 1'b1);
        pe = (frame_err === 1'b1);
    end

    // watchdog
    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        foreach (exp_q[i]) begin
            chk({tag, "_item"},
                (i < got.size()) ? {24'h0, got[i]} : 32'hdead,
                {24'h0, exp_q[i]});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(BIT);
    endtask

    task automatic send_frame(input logic [7:0] v, input bit stop_ok,
                              input bit par_good, input int hold_bits);
        t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
`ifdef UART_CMD_PARITY_EN
        send_bit((^v) ^ ~par_good);
`endif
        send_bit(stop_ok);
        if (!stop_ok) begin
            rx = 1'b0;
            tick(hold_bits * BIT);
        end
        rx = 1'b1;
        tick(8);
    endtask

    initial begin
        rx = 1'b1;
        reset_n = 1'b0;
        bus.cmd_ready = 1'b0;
        tick(4);

        chk("rst_cmd", bus.cmd, 4'h0);
        chk("rst_arg", bus.arg, 4'h0);
        chk("rst_valid", bus.cmd_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_busy", busy, 1'b0);

        reset_n = 1'b1;
        tick(4);

        // single byte, consumer always ready
        bus.cmd_ready = 1'b1;
        got.delete();
        e0 = err_pulses;
        valid_cycles = 0;
        valid_rise.delete();
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        tick(BIT);
        chk("a5_count", got.size(), 1);
        chk("a5_cmd", (got.size() > 0) ? got[0][3:0] : 4'hx, 4'h5);
        chk("a5_arg", (got.size() > 0) ? got[0][7:4] : 4'hx, 4'hA);
        chk("a5_vcycles", valid_cycles, 1);
        chk("a5_ferr", err_pulses - e0, 0);
        diff = (valid_rise.size() > 0) ? valid_rise[0] - t0 - LAT : 99;
        chk("a5_latency_ok", (diff >= -1 && diff <= 1), 1);

        // fill the FIFO past its depth with no consumer
        bus.cmd_ready = 1'b0;
        got.delete();
        exp_q.delete();
        ovf_exp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'h31 + 8'(i * 8'h11);
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(d);
            else ovf_exp = 1'b1;
            if (i == 4) chk("ovf_before_5th", overflow, 1'b0);
            send_frame(d, 1'b1, 1'b1, 0);
        end
        chk("ovf_after_5th", overflow, ovf_exp);
        chk("full_valid", bus.cmd_valid, 1'b1);
        chk("full_head_cmd", bus.cmd, exp_q[0][3:0]);
        chk("full_head_arg", bus.arg, exp_q[0][7:4]);
        bus.cmd_ready = 1'b1;
        tick(FIFO_DEPTH - 1);
        chk("drain_valid_last", bus.cmd_valid, 1'b1);
        tick(1);
        chk("drain_valid_empty", bus.cmd_valid, 1'b0);
        cmp_q("drain");
        chk("held_cmd", bus.cmd, 4'h4);
        chk("held_arg", bus.arg, 4'h6);

        // bad stop bit followed by a held-low line
        got.delete();
        e0 = err_pulses;
        err_rise.delete();
        t0 = cyc;
        d = 8'h12;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_CMD_PARITY_EN
        send_bit(^d);
`endif
        rx = 1'b0;
        tick(BIT);
        chk("brk_busy_a", busy, 1'b1);
        chk("brk_one_pulse", err_pulses - e0, 1);
        tick(3 * BIT);
        chk("brk_busy_b", busy, 1'b1);
        rx = 1'b1;
        tick(8);
        chk("brk_idle", busy, 1'b0);
        chk("brk_pulses", err_pulses - e0, 1);
        diff = (err_rise.size() > 0) ? err_rise[0] - t0 - LAT : 99;
        chk("brk_err_time_ok", (diff >= -1 && diff <= 1), 1);
        chk("brk_nowrite", got.size(), 0);
        chk("brk_valid", bus.cmd_valid, 1'b0);

        // short low glitch on idle line
        e0 = err_pulses;
        rx = 1'b0;
        tick(10);
        chk("glitch_busy", busy, 1'b1);
        tick(10);
        rx = 1'b1;
        tick(BIT);
        chk("glitch_idle", busy, 1'b0);
        chk("glitch_ferr", err_pulses - e0, 0);
        chk("glitch_nowrite", got.size(), 0);

        // reset in the middle of a 0xFF frame
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset_n = 1'b0;
        tick(2);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_valid", bus.cmd_valid, 1'b0);
        chk("mrst_ovf", overflow, 1'b0);
        chk("mrst_cmd", bus.cmd, 4'h0);
        chk("mrst_arg", bus.arg, 4'h0);
        reset_n = 1'b1;
        rx = 1'b1;
        tick(8 * BIT);
        chk("mrst_quiet", got.size(), 0);
        exp_q.delete();
        exp_q.push_back(8'h0C);
        send_frame(8'h0C, 1'b1, 1'b1, 0);
        tick(BIT);
        cmp_q("after_rst");

`ifdef UART_CMD_PARITY_EN
        // parity check on 0x03
        got.delete();
        exp_q.delete();
        e0 = err_pulses;
        send_frame(8'h03, 1'b1, 1'b0, 0);
        chk("par_bad_err", err_pulses - e0, 1);
        chk("par_bad_nowrite", got.size(), 0);
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 0);
        chk("par_good_err", err_pulses - e0, 1);
        cmp_q("par_good");
`endif

        // random traffic against a queue model of the FIFO
        got.delete();
        exp_q.delete();
        e0 = err_pulses;
        n_err_exp = 0;
        occ = 0;
        ovf_exp = 1'b0;
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            s_ok = ($urandom_range(0, 3) != 0);
`ifdef UART_CMD_PARITY_EN
            p_ok = ($urandom_range(0, 3) != 0);
`else
            p_ok = 1'b1;
`endif
            rdy = ($urandom_range(0, 1) == 1);
            bus.cmd_ready = rdy;
            if (rdy) occ = 0;
            if (!s_ok || !p_ok) begin
                n_err_exp++;
            end else if (rdy || occ < FIFO_DEPTH) begin
                exp_q.push_back(d);
                if (!rdy) occ++;
            end else begin
                ovf_exp = 1'b1;
            end
            send_frame(d, s_ok, p_ok, 1);
            tick($urandom_range(0, 40));
        end
        bus.cmd_ready = 1'b1;
        tick(10);
        cmp_q("rand");
        chk("rand_ferr", err_pulses - e0, n_err_exp);
        chk("rand_ovf", overflow, ovf_exp);
        chk("rand_valid", bus.cmd_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
